// File: rtl/mips_multicycle_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl_if
// Brief    : Shared-memory request/ready handshake between the multicycle
//            MIPS controller (master) and the memory (slave).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemWrite,
        output mem_ready
    );
endinterface

`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : mips_multicycle_ctrl
// Brief    : Moore FSM sequencing a multicycle MIPS datapath (shared memory,
//            one ALU) with a bounded-wait memory handshake.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  wire                    clk,
    input  wire                    rst_n,
    mips_multicycle_ctrl_if.master mem,
    input  wire  [5:0]             op,
    input  wire  [5:0]             Funct,
    input  wire                    Zero,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSrc,
    output logic                   PCEn,
    output logic [2:0]             ALU_ctrl,
    output logic                   illegal_op,
    output logic                   bus_err,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_illegal;

    // Per-state decode, registered from the next state so it is glitch-free.
    logic             r_is_fetch;
    logic             r_is_memwr;
    logic             r_is_branch;
    logic             r_is_jump;
    logic             r_is_exec;
    logic             r_mem_req;
    logic             r_iord;
    logic             r_regdst;
    logic             r_memtoreg;
    logic             r_regwrite;
    logic             r_alusrca;
    logic [1:0]       r_alusrcb;
    logic [1:0]       r_pcsrc;
    logic             r_illegal;
    logic             r_bus_err;

    always_comb begin
        w_waiting = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
        // mem_ready has priority over an expiring wait
        w_timeout = w_waiting && !mem.mem_ready && (r_wait_cnt == c_WAIT_LAST);
        w_illegal = 1'b0;
        w_next    = S_FETCH;

        case (r_state)
            S_FETCH:   w_next = mem.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  w_next = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = mem.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = mem.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase

        if (w_timeout) begin
            w_next = S_FETCH;
        end

        if (!w_waiting || mem.mem_ready || w_timeout || (w_next != r_state)) begin
            w_wait_cnt_nxt = '0;
        end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_wait_cnt  <= '0;
            r_illegal   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_is_fetch  <= 1'b1;
            r_is_memwr  <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
            r_is_exec   <= 1'b0;
            r_mem_req   <= 1'b1;
            r_iord      <= 1'b0;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_regwrite  <= 1'b0;
            r_alusrca   <= 1'b0;
            r_alusrcb   <= 2'b01;
            r_pcsrc     <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_illegal   <= w_illegal;
            r_bus_err   <= w_timeout;

            r_is_fetch  <= 1'b0;
            r_is_memwr  <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
            r_is_exec   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_iord      <= 1'b0;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_regwrite  <= 1'b0;
            r_alusrca   <= 1'b0;
            r_alusrcb   <= 2'b00;
            r_pcsrc     <= 2'b00;

            case (w_next)
                S_FETCH: begin
                    r_is_fetch <= 1'b1;
                    r_mem_req  <= 1'b1;
                    r_alusrcb  <= 2'b01;
                end
                S_DECODE: begin
                    r_alusrcb  <= 2'b11;
                end
                S_MEMADR: begin
                    r_alusrca  <= 1'b1;
                    r_alusrcb  <= 2'b10;
                end
                S_MEMRD: begin
                    r_mem_req  <= 1'b1;
                    r_iord     <= 1'b1;
                end
                S_MEMWB: begin
                    r_memtoreg <= 1'b1;
                    r_regwrite <= 1'b1;
                end
                S_MEMWR: begin
                    r_mem_req  <= 1'b1;
                    r_iord     <= 1'b1;
                    r_is_memwr <= 1'b1;
                end
                S_EXECUTE: begin
                    r_alusrca  <= 1'b1;
                    r_is_exec  <= 1'b1;
                end
                S_ALUWB: begin
                    r_regdst   <= 1'b1;
                    r_regwrite <= 1'b1;
                end
                S_BRANCH: begin
                    r_alusrca   <= 1'b1;
                    r_pcsrc     <= 2'b01;
                    r_is_branch <= 1'b1;
                end
                S_ADDIEX: begin
                    r_alusrca  <= 1'b1;
                    r_alusrcb  <= 2'b10;
                end
                S_ADDIWB: begin
                    r_regwrite <= 1'b1;
                end
                S_JUMP: begin
                    r_pcsrc    <= 2'b10;
                    r_is_jump  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        ALU_ctrl = 3'b010;
        if (r_is_branch) begin
            ALU_ctrl = 3'b110;
        end else if (r_is_exec) begin
            case (Funct)
                6'b100000: ALU_ctrl = 3'b010;
                6'b100010: ALU_ctrl = 3'b110;
                6'b100100: ALU_ctrl = 3'b000;
                6'b100101: ALU_ctrl = 3'b001;
                6'b101010: ALU_ctrl = 3'b111;
                default:   ALU_ctrl = 3'b010;
            endcase
        end
    end

    // Write strobes qualify with rst_n so nothing fires while reset is held.
    assign mem.mem_req  = r_mem_req & rst_n;
    assign mem.IorD     = r_iord;
    assign mem.MemWrite = r_is_memwr & mem.mem_ready & rst_n;
    assign IRWrite      = r_is_fetch & mem.mem_ready & rst_n;
    assign PCEn         = rst_n & ((r_is_fetch & mem.mem_ready) | r_is_jump | (r_is_branch & Zero));
    assign RegWrite     = r_regwrite & rst_n;
    assign RegDst       = r_regdst;
    assign MemtoReg     = r_memtoreg;
    assign ALUSrcA      = r_alusrca;
    assign ALUSrcB      = r_alusrcb;
    assign PCSrc        = r_pcsrc;
    assign illegal_op   = r_illegal;
    assign bus_err      = r_bus_err;
    assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_multicycle_ctrl
// Brief    : Self-checking bench: vector table, corner sequences, and random
//            traffic against an instruction-plan reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op    = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero  = 1'b0;
    logic       IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal_op, bus_err;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALU_ctrl;
    logic [3:0] state;

    mips_multicycle_ctrl_if mem_bus ();

    mips_multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mem_bus),
        .op         (op),
        .Funct      (Funct),
        .Zero       (Zero),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCEn       (PCEn),
        .ALU_ctrl   (ALU_ctrl),
        .illegal_op (illegal_op),
        .bus_err    (bus_err),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_bus.mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic [4:0] strb;   // {mem_req, MemWrite, IRWrite, RegWrite, PCEn}
        logic [2:0] alu;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic mr, input logic [3:0] st, input logic [4:0] s, input logic [2:0] a);
        vec_t v;
        v.rst_n = r; v.op = o; v.fn = f; v.z = z; v.mr = mr; v.st = st; v.strb = s; v.alu = a;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int   plan[$];
    int   waits;
    logic e_ill, e_berr;

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // {state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
    //  ALUSrcA, ALUSrcB, PCSrc, PCEn, ALU_ctrl, illegal_op, bus_err}
    function automatic logic [21:0] exp_vec(input int st, input logic mr, input logic z,
                                            input logic [5:0] fn, input logic ill, input logic be);
        logic mq, io, mw, ir, rd, m2r, rw, sa, pe;
        logic [1:0] sb, ps;
        logic [2:0] al;
        {mq, io, mw, ir, rd, m2r, rw, sa, pe} = '0;
        sb = 2'b00; ps = 2'b00; al = 3'b010;
        case (st)
            0:  begin mq = 1; sb = 2'b01; ir = mr; pe = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mq = 1; io = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mq = 1; io = 1; mw = mr; end
            6:  begin sa = 1; al = alu_of(fn); end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; al = 3'b110; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {4'(st), mq, io, mw, ir, rd, m2r, rw, sa, sb, ps, pe, al, ill, be};
    endfunction

    function automatic logic [21:0] act_vec();
        return {state, mem_bus.mem_req, mem_bus.IorD, mem_bus.MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, PCEn, ALU_ctrl, illegal_op, bus_err};
    endfunction

    task automatic model_step(input logic mr, input logic [5:0] opc);
        int   cur;
        logic ni, nb;
        cur = plan[0]; ni = 1'b0; nb = 1'b0;
        if (cur == 0 || cur == 3 || cur == 5) begin
            if (mr) begin
                void'(plan.pop_front());
                waits = 0;
                if (cur == 0) plan.push_back(1);
            end else begin
                waits++;
                if (waits == TO) begin
                    plan.delete();
                    waits = 0;
                    nb = 1'b1;
                end
            end
        end else begin
            void'(plan.pop_front());
            if (cur == 1) begin
                case (opc)
                    6'h23:   begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
                    6'h2B:   begin plan.push_back(2); plan.push_back(5); end
                    6'h00:   begin plan.push_back(6); plan.push_back(7); end
                    6'h04:   plan.push_back(8);
                    6'h08:   begin plan.push_back(9); plan.push_back(10); end
                    6'h02:   plan.push_back(11);
                    default: ni = 1'b1;
                endcase
            end
        end
        if (plan.size() == 0) plan.push_back(0);
        e_ill  = ni;
        e_berr = nb;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};

        mem_bus.mem_ready = 1'b0;

        // lw, slt, beq taken/not, j, addi with memory always ready
        add(0, 6'h23, 0, 0, 1, 0, 5'b00000, 3'b010);
        add(1, 6'h23, 0, 0, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h23, 0, 0, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h23, 0, 0, 1, 2, 5'b00000, 3'b010);
        add(1, 6'h23, 0, 0, 1, 3, 5'b10000, 3'b010);
        add(1, 6'h23, 0, 0, 1, 4, 5'b00010, 3'b010);
        add(1, 6'h00, 6'h2A, 0, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h00, 6'h2A, 0, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h00, 6'h2A, 0, 1, 6, 5'b00000, 3'b111);
        add(1, 6'h00, 6'h2A, 0, 1, 7, 5'b00010, 3'b010);
        add(1, 6'h04, 0, 1, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h04, 0, 1, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h04, 0, 1, 1, 8, 5'b00001, 3'b110);
        add(1, 6'h04, 0, 0, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h04, 0, 0, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h04, 0, 0, 1, 8, 5'b00000, 3'b110);
        add(1, 6'h02, 0, 0, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h02, 0, 0, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h02, 0, 0, 1, 11, 5'b00001, 3'b010);
        add(1, 6'h08, 0, 0, 1, 0, 5'b10101, 3'b010);
        add(1, 6'h08, 0, 0, 1, 1, 5'b00000, 3'b010);
        add(1, 6'h08, 0, 0, 1, 9, 5'b00000, 3'b010);
        add(1, 6'h08, 0, 0, 1, 10, 5'b00010, 3'b010);

        tick();
        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n; op = tbl[i].op; Funct = tbl[i].fn;
            Zero = tbl[i].z; mem_bus.mem_ready = tbl[i].mr;
            @(negedge clk);
            check($sformatf("tbl_state[%0d]", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("tbl_strobes[%0d]", i),
                  32'({mem_bus.mem_req, mem_bus.MemWrite, IRWrite, RegWrite, PCEn}), 32'(tbl[i].strb));
            check($sformatf("tbl_alu[%0d]", i), 32'(ALU_ctrl), 32'(tbl[i].alu));
            tick();
        end

        // sw with three wait cycles in MEMWR
        do_reset();
        op = 6'h2B; Funct = 6'h00; mem_bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); check("sw_pre_state", 32'(state), 32'(k)); tick();
        end
        mem_bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sw_wait_state", 32'(state), 32'd5);
            check("sw_wait_memwrite", 32'(mem_bus.MemWrite), 32'd0);
            check("sw_wait_req", 32'({mem_bus.mem_req, mem_bus.IorD}), 32'b11);
            tick();
        end
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        check("sw_done_state", 32'(state), 32'd5);
        check("sw_done_memwrite", 32'(mem_bus.MemWrite), 32'd1);
        tick();
        @(negedge clk);
        check("sw_after_state", 32'(state), 32'd0);
        check("sw_after_bus_err", 32'(bus_err), 32'd0);

        // fetch timeout
        do_reset();
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            check("to_state", 32'(state), 32'd0);
            check("to_strobes", 32'({IRWrite, PCEn, bus_err}), 32'd0);
            tick();
        end
        @(negedge clk);
        check("to_state_after", 32'(state), 32'd0);
        check("to_bus_err_pulse", 32'(bus_err), 32'd1);
        tick();
        @(negedge clk);
        check("to_bus_err_clear", 32'(bus_err), 32'd0);

        // illegal opcode
        do_reset();
        op = 6'h3F; mem_bus.mem_ready = 1'b1;
        @(negedge clk); check("ill_fetch", 32'(state), 32'd0); tick();
        @(negedge clk);
        check("ill_decode", 32'(state), 32'd1);
        check("ill_flag_decode", 32'(illegal_op), 32'd0);
        tick();
        mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        check("ill_back_fetch", 32'(state), 32'd0);
        check("ill_pulse", 32'(illegal_op), 32'd1);
        tick();
        @(negedge clk); check("ill_pulse_end", 32'(illegal_op), 32'd0);

        // reset asserted during ALUWB
        do_reset();
        op = 6'h00; Funct = 6'h20; mem_bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); tick();
        end
        @(negedge clk);
        check("rst_aluwb_state", 32'(state), 32'd7);
        check("rst_aluwb_regwrite", 32'({RegWrite, RegDst}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid_regwrite", 32'(RegWrite), 32'd0);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_memreq", 32'(mem_bus.mem_req), 32'd0);
        tick();
        rst_n = 1'b1;

        // randomized traffic against the plan model
        do_reset();
        plan.delete(); plan.push_back(0); waits = 0; e_ill = 1'b0; e_berr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (plan[0] == 0) begin
                op    = ops[$urandom_range(0, 6)];
                Funct = fns[$urandom_range(0, 5)];
            end
            Zero = 1'($urandom_range(0, 1));
            mem_bus.mem_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            check($sformatf("rand[%0d]", i), 32'(act_vec()),
                  32'(exp_vec(plan[0], mem_bus.mem_ready, Zero, Funct, e_ill, e_berr)));
            model_step(mem_bus.mem_ready, op);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
